load_store_unit: RTL and testbench

Parametrised, multi-cycle load/store unit between the EX stage and a handshaked data memory. It replaces the single-cycle memory path with an FSM that does the following:
- generates byte enables and lane-replicated store data;
- sign/zero-extends load data;
- traps misaligned or illegal accesses;
- aborts on bus timeout.

The pipeline stalls on req_ready low. Write-back is delivered as a one-cycle pulse.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 76 +++++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// funct3 width/sign codes, error causes and the access-size helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 4'd1;
      F3_H, F3_HU: return 4'd2;
      F3_W, F3_WU: return 4'd4;
      default:     return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, replicated store data,
// shifted and extended load data, plus misalign/illegal access flags.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [2:0]            addr_lo,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W-1:0]     rdata,
  output logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     wdata_rep,
  output logic [DATA_W-1:0]     rdata_ext,
  output logic                  misalign,
  output logic                  illegal
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W-1:0]  off;
  logic [3:0]        size;
  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    off  = addr_lo[OFF_W-1:0];
    size = size_bytes(funct3);

    case (size)
      4'd1:    mask = NB'(1);
      4'd2:    mask = NB'(3);
      4'd4:    mask = NB'(15);
      default: mask = '1;
    endcase
    be = mask << off;

    case (size)
      4'd1:    wdata_rep = {NB{wdata[7:0]}};
      4'd2:    wdata_rep = {(NB/2){wdata[15:0]}};
      4'd4:    wdata_rep = {(NB/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase

    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata_ext = DATA_W'($signed(shifted[7:0]));
      F3_H:    rdata_ext = DATA_W'($signed(shifted[15:0]));
      F3_W:    rdata_ext = DATA_W'($signed(shifted[31:0]));
      F3_BU:   rdata_ext = DATA_W'(shifted[7:0]);
      F3_HU:   rdata_ext = DATA_W'(shifted[15:0]);
      F3_WU:   rdata_ext = DATA_W'(shifted[31:0]);
      default: rdata_ext = shifted;
    endcase

    misalign = |(addr_lo & 3'(size - 4'd1));

    // Doubleword forms only exist on a 64-bit bus; stores have no unsigned forms
    if (we) begin
      case (funct3)
        F3_B, F3_H, F3_W: illegal = 1'b0;
        F3_D:             illegal = (DATA_W != 64);
        default:          illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal = 1'b0;
        F3_D, F3_WU:                    illegal = (DATA_W != 64);
        default:                        illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between EX and a handshaked data memory.
// state   | meaning
// IDLE    | ready for a request; errors are reported from here
// REQ     | mem_req held with stable address/data until mem_gnt
// WAIT_RD | load granted, waiting for mem_rvalid
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  st_done,
  output logic                  err_valid,
  output logic [1:0]            err_cause,
  output logic [ADDR_W-1:0]     err_addr
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  lsu_state_e        state, state_next;
  logic              lat_we;
  logic [2:0]        lat_funct3;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [4:0]        lat_rd;
  logic [TW-1:0]     timer;
  logic              accept, tmo;

  logic              a_we;
  logic [2:0]        a_funct3;
  logic [2:0]        a_addr_lo;
  logic [DATA_W-1:0] a_wdata;
  logic [NB-1:0]     a_be;
  logic [DATA_W-1:0] a_wdata_rep, a_rdata_ext;
  logic              a_misalign, a_illegal;

  // In IDLE the aligner checks the incoming request; otherwise it serves the latched one
  always_comb begin
    a_we      = (state == IDLE) ? req_we     : lat_we;
    a_funct3  = (state == IDLE) ? req_funct3 : lat_funct3;
    a_addr_lo = (state == IDLE) ? req_addr[2:0] : lat_addr[2:0];
    a_wdata   = (state == IDLE) ? req_wdata  : lat_wdata;
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .we        (a_we),
    .funct3    (a_funct3),
    .addr_lo   (a_addr_lo),
    .wdata     (a_wdata),
    .rdata     (mem_rdata),
    .be        (a_be),
    .wdata_rep (a_wdata_rep),
    .rdata_ext (a_rdata_ext),
    .misalign  (a_misalign),
    .illegal   (a_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    tmo        = (timer == TLAST);
    case (state)
      IDLE: begin
        accept = req_valid;
        if (req_valid && !a_illegal && !a_misalign) state_next = REQ;
      end
      REQ: begin
        if (mem_gnt)  state_next = lat_we ? IDLE : WAIT_RD;
        else if (tmo) state_next = IDLE;
      end
      WAIT_RD: begin
        if (mem_rvalid || tmo) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_we    = mem_req & lat_we;
    mem_addr  = mem_req ? {lat_addr[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
    mem_be    = mem_req ? a_be : '0;
    mem_wdata = mem_req ? a_wdata_rep : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      lat_we     <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_rd     <= '0;
      timer      <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      st_done    <= 1'b0;
      err_valid  <= 1'b0;
      err_cause  <= '0;
      err_addr   <= '0;
    end else begin
      mem_req   <= (state_next == REQ);
      wb_valid  <= 1'b0;
      st_done   <= 1'b0;
      err_valid <= 1'b0;

      if (state_next == state && state != IDLE) timer <= timer + TW'(1);
      else                                      timer <= '0;

      if (accept) begin
        lat_we     <= req_we;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_rd     <= req_rd;
        if (a_illegal) begin
          err_valid <= 1'b1;
          err_cause <= ERR_ILLEGAL;
          err_addr  <= req_addr;
        end else if (a_misalign) begin
          err_valid <= 1'b1;
          err_cause <= ERR_MISALIGN;
          err_addr  <= req_addr;
        end
      end

      // A handshake in the same cycle as the last timer count takes precedence
      if (state == REQ) begin
        if (mem_gnt) begin
          st_done <= lat_we;
        end else if (tmo) begin
          err_valid <= 1'b1;
          err_cause <= ERR_TIMEOUT;
          err_addr  <= lat_addr;
        end
      end

      if (state == WAIT_RD) begin
        if (mem_rvalid) begin
          wb_valid <= 1'b1;
          wb_rd    <= lat_rd;
          wb_data  <= a_rdata_ext;
        end else if (tmo) begin
          err_valid <= 1'b1;
          err_cause <= ERR_TIMEOUT;
          err_addr  <= lat_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit and a 64-bit instance share
// stimulus; a table of single-access vectors plus multi-cycle corner sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam logic [1:0] K_ST  = 2'd0;
  localparam logic [1:0] K_LD  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        d64;
    logic [1:0]  kind;
    logic [7:0]  be;
    logic [63:0] exp_wd;
    logic [63:0] exp_rd;
    logic [1:0]  cause;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_we, mem_gnt, mem_rvalid, sel64;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic [4:0]  req_rd;

  logic rr32, mreq32, mwe32, wbv32, std32, errv32;
  logic [8:0] maddr32, erra32;
  logic [3:0] mbe32;
  logic [31:0] mwd32, wbd32;
  logic [4:0] wbrd32;
  logic [1:0] errc32;

  logic rr64, mreq64, mwe64, wbv64, std64, errv64;
  logic [8:0] maddr64, erra64;
  logic [7:0] mbe64;
  logic [63:0] mwd64, wbd64;
  logic [4:0] wbrd64;
  logic [1:0] errc64;

  logic o_rr, o_mreq, o_mwe, o_wbv, o_std, o_errv;
  logic [8:0] o_maddr, o_erra;
  logic [7:0] o_mbe;
  logic [63:0] o_mwd, o_wbd;
  logic [4:0] o_wbrd;
  logic [1:0] o_errc;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[23];

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(16)) dut32 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel64), .req_ready(rr32),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
    .mem_req(mreq32), .mem_we(mwe32), .mem_addr(maddr32), .mem_be(mbe32),
    .mem_wdata(mwd32), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata[31:0]), .wb_valid(wbv32), .wb_rd(wbrd32),
    .wb_data(wbd32), .st_done(std32), .err_valid(errv32),
    .err_cause(errc32), .err_addr(erra32)
  );

  load_store_unit #(.DATA_W(64), .ADDR_W(9), .TIMEOUT(16)) dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel64), .req_ready(rr64),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64), .mem_be(mbe64),
    .mem_wdata(mwd64), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wbv64), .wb_rd(wbrd64),
    .wb_data(wbd64), .st_done(std64), .err_valid(errv64),
    .err_cause(errc64), .err_addr(erra64)
  );

  always_comb begin
    o_rr    = sel64 ? rr64   : rr32;
    o_mreq  = sel64 ? mreq64 : mreq32;
    o_mwe   = sel64 ? mwe64  : mwe32;
    o_maddr = sel64 ? maddr64 : maddr32;
    o_mbe   = sel64 ? mbe64  : {4'b0, mbe32};
    o_mwd   = sel64 ? mwd64  : {32'b0, mwd32};
    o_wbv   = sel64 ? wbv64  : wbv32;
    o_wbrd  = sel64 ? wbrd64 : wbrd32;
    o_wbd   = sel64 ? wbd64  : {32'b0, wbd32};
    o_std   = sel64 ? std64  : std32;
    o_errv  = sel64 ? errv64 : errv32;
    o_errc  = sel64 ? errc64 : errc32;
    o_erra  = sel64 ? erra64 : erra32;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                           input logic [63:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
  endtask

  task automatic run_vec(input vec_t v);
    logic [8:0] exp_maddr;
    exp_maddr = v.d64 ? (v.addr & 9'h1F8) : (v.addr & 9'h1FC);
    @(negedge clk);
    sel64 = v.d64;
    #1;
    check("ready_before", {63'b0, o_rr}, 64'd1);
    drive_req(v.we, v.f3, v.addr, v.wdata, v.rd);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.kind == K_ERR) begin
      check("err_valid", {63'b0, o_errv}, 64'd1);
      check("err_cause", {62'b0, o_errc}, {62'b0, v.cause});
      check("err_addr", {55'b0, o_erra}, {55'b0, v.addr});
      check("err_no_req", {63'b0, o_mreq}, 64'd0);
      check("err_ready", {63'b0, o_rr}, 64'd1);
    end else begin
      check("mem_req", {63'b0, o_mreq}, 64'd1);
      check("mem_we", {63'b0, o_mwe}, {63'b0, v.we});
      check("mem_addr", {55'b0, o_maddr}, {55'b0, exp_maddr});
      check("mem_be", {56'b0, o_mbe}, {56'b0, v.be});
      if (v.kind == K_ST) check("mem_wdata", o_mwd, v.exp_wd);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("req_drop", {63'b0, o_mreq}, 64'd0);
      if (v.kind == K_ST) begin
        check("st_done", {63'b0, o_std}, 64'd1);
      end else begin
        check("wb_early", {63'b0, o_wbv}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check("wb_valid", {63'b0, o_wbv}, 64'd1);
        check("wb_rd", {59'b0, o_wbrd}, {59'b0, v.rd});
        check("wb_data", o_wbd, v.exp_rd);
        @(negedge clk);
        check("wb_pulse", {63'b0, o_wbv}, 64'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    f3     addr    wdata                   rdata                   rd     d64   kind   be     exp_wd                  exp_rd                  cause
    vecs[0]  = '{1'b1, F3_B,  9'h0A3, 64'h12345678,           64'h0,                  5'd0,  1'b0, K_ST,  8'h08, 64'h78787878,           64'h0,                  2'd0};
    vecs[1]  = '{1'b0, F3_H,  9'h006, 64'h0,                  64'h80011234,           5'd5,  1'b0, K_LD,  8'h0C, 64'h0,                  64'hFFFF8001,           2'd0};
    vecs[2]  = '{1'b0, F3_HU, 9'h006, 64'h0,                  64'h80011234,           5'd17, 1'b0, K_LD,  8'h0C, 64'h0,                  64'h00008001,           2'd0};
    vecs[3]  = '{1'b0, F3_W,  9'h0A2, 64'h0,                  64'h0,                  5'd2,  1'b0, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b01};
    vecs[4]  = '{1'b0, F3_D,  9'h000, 64'h0,                  64'h0,                  5'd2,  1'b0, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b10};
    vecs[5]  = '{1'b0, F3_B,  9'h001, 64'h0,                  64'h00008000,           5'd1,  1'b0, K_LD,  8'h02, 64'h0,                  64'hFFFFFF80,           2'd0};
    vecs[6]  = '{1'b0, F3_BU, 9'h003, 64'h0,                  64'hAB000000,           5'd31, 1'b0, K_LD,  8'h08, 64'h0,                  64'h000000AB,           2'd0};
    vecs[7]  = '{1'b1, F3_H,  9'h002, 64'hCAFEBEEF,           64'h0,                  5'd0,  1'b0, K_ST,  8'h0C, 64'hBEEFBEEF,           64'h0,                  2'd0};
    vecs[8]  = '{1'b1, F3_W,  9'h004, 64'h11223344,           64'h0,                  5'd0,  1'b0, K_ST,  8'h0F, 64'h11223344,           64'h0,                  2'd0};
    vecs[9]  = '{1'b0, F3_W,  9'h010, 64'h0,                  64'h89ABCDEF,           5'd9,  1'b0, K_LD,  8'h0F, 64'h0,                  64'h89ABCDEF,           2'd0};
    vecs[10] = '{1'b1, F3_BU, 9'h010, 64'h0,                  64'h0,                  5'd0,  1'b0, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b10};
    vecs[11] = '{1'b1, F3_H,  9'h001, 64'h0,                  64'h0,                  5'd0,  1'b0, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b01};
    vecs[12] = '{1'b0, 3'b111,9'h003, 64'h0,                  64'h0,                  5'd0,  1'b0, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b10};
    vecs[13] = '{1'b0, F3_WU, 9'h000, 64'h0,                  64'h0,                  5'd0,  1'b0, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b10};
    vecs[14] = '{1'b0, F3_D,  9'h008, 64'h0,                  64'hDEADBEEF00000001,   5'd3,  1'b1, K_LD,  8'hFF, 64'h0,                  64'hDEADBEEF00000001,   2'd0};
    vecs[15] = '{1'b0, F3_WU, 9'h00C, 64'h0,                  64'hDEADBEEF00000001,   5'd4,  1'b1, K_LD,  8'hF0, 64'h0,                  64'h00000000DEADBEEF,   2'd0};
    vecs[16] = '{1'b0, F3_W,  9'h00C, 64'h0,                  64'hDEADBEEF00000001,   5'd6,  1'b1, K_LD,  8'hF0, 64'h0,                  64'hFFFFFFFFDEADBEEF,   2'd0};
    vecs[17] = '{1'b1, F3_B,  9'h005, 64'hA5,                 64'h0,                  5'd0,  1'b1, K_ST,  8'h20, 64'hA5A5A5A5A5A5A5A5,   64'h0,                  2'd0};
    vecs[18] = '{1'b1, F3_D,  9'h010, 64'h0123456789ABCDEF,   64'h0,                  5'd0,  1'b1, K_ST,  8'hFF, 64'h0123456789ABCDEF,   64'h0,                  2'd0};
    vecs[19] = '{1'b0, F3_D,  9'h004, 64'h0,                  64'h0,                  5'd0,  1'b1, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b01};
    vecs[20] = '{1'b1, F3_W,  9'h00C, 64'hCAFEF00D,           64'h0,                  5'd0,  1'b1, K_ST,  8'hF0, 64'hCAFEF00DCAFEF00D,   64'h0,                  2'd0};
    vecs[21] = '{1'b0, F3_H,  9'h00E, 64'h0,                  64'h8000000000000000,   5'd7,  1'b1, K_LD,  8'hC0, 64'h0,                  64'hFFFFFFFFFFFF8000,   2'd0};
    vecs[22] = '{1'b1, F3_WU, 9'h000, 64'h0,                  64'h0,                  5'd0,  1'b1, K_ERR, 8'h00, 64'h0,                  64'h0,                  2'b10};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    sel64 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {63'b0, o_rr}, 64'd1);
    check("rst_mem_req", {63'b0, o_mreq}, 64'd0);
    check("rst_mem_be", {56'b0, o_mbe}, 64'd0);
    check("rst_mem_addr", {55'b0, o_maddr}, 64'd0);
    check("rst_outputs", {60'b0, o_wbv, o_std, o_errv, o_mwe}, 64'd0);

    for (int i = 0; i < 23; i++) run_vec(vecs[i]);

    // Store timeout: gnt held low for all 16 REQ cycles
    @(negedge clk);
    sel64 = 1'b0;
    drive_req(1'b1, F3_W, 9'h020, 64'h11112222, 5'd0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("to_req_c16", {63'b0, o_mreq}, 64'd1);
    check("to_stable_addr", {55'b0, o_maddr}, 64'h020);
    check("to_stable_be", {56'b0, o_mbe}, 64'h0F);
    check("to_stable_wd", o_mwd, 64'h11112222);
    check("to_no_err_yet", {63'b0, o_errv}, 64'd0);
    @(negedge clk);
    check("to_err_valid", {63'b0, o_errv}, 64'd1);
    check("to_err_cause", {62'b0, o_errc}, 64'd3);
    check("to_err_addr", {55'b0, o_erra}, 64'h020);
    check("to_req_low", {63'b0, o_mreq}, 64'd0);
    check("to_ready", {63'b0, o_rr}, 64'd1);

    // Grant on the 16th REQ cycle beats the timeout
    @(negedge clk);
    drive_req(1'b1, F3_W, 9'h024, 64'h33334444, 5'd0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("gnt16_st_done", {63'b0, o_std}, 64'd1);
    check("gnt16_no_err", {63'b0, o_errv}, 64'd0);

    // rvalid coincident with gnt is ignored; later rvalid completes the load
    @(negedge clk);
    drive_req(1'b0, F3_W, 9'h008, 64'h0, 5'd12);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0BAD0;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    check("co_req_low", {63'b0, o_mreq}, 64'd0);
    @(negedge clk);
    check("co_not_taken", {63'b0, o_wbv}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h00000055;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("co_wb_valid", {63'b0, o_wbv}, 64'd1);
    check("co_wb_data", o_wbd, 64'h55);
    check("co_wb_rd", {59'b0, o_wbrd}, 64'd12);

    // Load timeout in WAIT_RD
    @(negedge clk);
    drive_req(1'b0, F3_W, 9'h00C, 64'h0, 5'd8);
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (15) @(negedge clk);
    check("rto_no_err_yet", {63'b0, o_errv}, 64'd0);
    @(negedge clk);
    check("rto_err_valid", {63'b0, o_errv}, 64'd1);
    check("rto_err_cause", {62'b0, o_errc}, 64'd3);
    check("rto_err_addr", {55'b0, o_erra}, 64'h00C);
    check("rto_ready", {63'b0, o_rr}, 64'd1);

    // Reset during WAIT_RD, late rvalid afterwards must be ignored
    @(negedge clk);
    drive_req(1'b0, F3_W, 9'h040, 64'h0, 5'd20);
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_req", {63'b0, o_mreq}, 64'd0);
    check("rst_mid_ready", {63'b0, o_rr}, 64'd1);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("late_rv_no_wb", {63'b0, o_wbv}, 64'd0);
    check("late_rv_no_err", {63'b0, o_errv}, 64'd0);
    check("late_rv_cause", {62'b0, o_errc}, 64'd0);
    check("late_rv_wbdata", o_wbd, 64'd0);
    check("late_rv_ready", {63'b0, o_rr}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
